// File: rtl/bcd_digit_scanner.sv
// rtl/bcd_digit_scanner.sv - time-multiplexed BCD digit scanner with leading-zero blanking
// Active data only changes at the frame wrap so a displayed frame never mixes old and new digits.
module bcd_digit_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int TICK_DIV      = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         act_bcd, shd_bcd;
  logic [NUM_DIGITS-1:0] act_dp, shd_dp;
  logic                  pending;

  logic                  advance, wrap;
  logic [IW-1:0]         nidx;
  logic [DW-1:0]         nact_bcd;
  logic [NUM_DIGITS-1:0] nact_dp;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] en_next;
  logic                  above_zero;
  logic [3:0]            sel_bcd;
  logic                  sel_dp, sel_blank;

  always_comb begin
    advance = (presc == PW'(TICK_DIV - 1));
    wrap    = advance && (idx == IW'(NUM_DIGITS - 1));
    if (!advance)
      nidx = idx;
    else if (wrap)
      nidx = '0;
    else
      nidx = idx + 1'b1;

    // A load on the wrap edge bypasses the shadow so digit 0 shows it immediately.
    if (wrap && load) begin
      nact_bcd = bcd_in;
      nact_dp  = dp_in;
    end else if (wrap && pending) begin
      nact_bcd = shd_bcd;
      nact_dp  = shd_dp;
    end else begin
      nact_bcd = act_bcd;
      nact_dp  = act_dp;
    end
  end

  // Blanking propagates down from the top digit and stops at the first nonzero code.
  always_comb begin
    blank      = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      above_zero = above_zero && (nact_bcd[4*i +: 4] == 4'd0);
      blank[i]   = above_zero && (BLANK_LEADING != 0);
    end
  end

  always_comb begin
    en_next   = '0;
    sel_bcd   = 4'd0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      en_next[i] = (nidx == IW'(i));
      if (nidx == IW'(i)) begin
        sel_bcd   = nact_bcd[4*i +: 4];
        sel_dp    = nact_dp[i];
        sel_blank = blank[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      act_bcd    <= '0;
      act_dp     <= '0;
      shd_bcd    <= '0;
      shd_dp     <= '0;
      pending    <= 1'b0;
      digit_en   <= NUM_DIGITS'(1);
      digit_bcd  <= 4'd0;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      presc   <= advance ? '0 : presc + 1'b1;
      idx     <= nidx;
      act_bcd <= nact_bcd;
      act_dp  <= nact_dp;
      if (load && !wrap) begin
        shd_bcd <= bcd_in;
        shd_dp  <= dp_in;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
      digit_en   <= en_next;
      digit_bcd  <= sel_blank ? 4'hF : sel_bcd;
      dp_out     <= sel_dp && !sel_blank;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb/tb_bcd_digit_scanner.sv - bench for bcd_digit_scanner (blanking and non-blanking instances)
// Both instances share stimulus; expected frames come from a hand-computed vector table.
module tb_bcd_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_bcd, digit_bcd0;
  logic [3:0]  digit_en, digit_en0;
  logic        dp_out, dp_out0, frame_done, frame_done0;

  always #5 clk = ~clk;

  bcd_digit_scanner #(.NUM_DIGITS(4), .TICK_DIV(4), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .digit_bcd(digit_bcd), .digit_en(digit_en), .dp_out(dp_out), .frame_done(frame_done)
  );

  bcd_digit_scanner #(.NUM_DIGITS(4), .TICK_DIV(4), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .digit_bcd(digit_bcd0), .digit_en(digit_en0), .dp_out(dp_out0), .frame_done(frame_done0)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [15:0] exp_code;
    logic [3:0]  exp_dp;
  } vec_t;

  typedef struct {
    logic [3:0] en;
    logic [3:0] code;
    logic       dp;
    logic [3:0] code0;
    logic       dp0;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[8];
  vec_t cur;
  vec_t rst_frame;

  task automatic check_next(input string name);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sbq.pop_front();
    if (digit_en !== e.en || digit_bcd !== e.code || dp_out !== e.dp || frame_done !== e.fd ||
        digit_en0 !== e.en || digit_bcd0 !== e.code0 || dp_out0 !== e.dp0 || frame_done0 !== e.fd) begin
      miscompares++;
      $display("FAIL %s: got en=%b bcd=%h dp=%b fd=%b nb_en=%b nb_bcd=%h nb_dp=%b nb_fd=%b want en=%b bcd=%h dp=%b fd=%b nb_bcd=%h nb_dp=%b",
               name, digit_en, digit_bcd, dp_out, frame_done, digit_en0, digit_bcd0, dp_out0,
               frame_done0, e.en, e.code, e.dp, e.fd, e.code0, e.dp0);
    end
  endtask

  task automatic push_one(input logic [3:0] en, input logic [3:0] code, input logic dp,
                          input logic [3:0] code0, input logic dp0, input logic fd);
    exp_t e;
    e.en = en; e.code = code; e.dp = dp; e.code0 = code0; e.dp0 = dp0; e.fd = fd;
    sbq.push_back(e);
  endtask

  task automatic push_frame(input vec_t v);
    for (int d = 0; d < 4; d++)
      push_one(4'(1 << d), v.exp_code[4*d +: 4], v.exp_dp[d], v.bcd[4*d +: 4], v.dp[d], d == 0);
  endtask

  task automatic sync_frame(input string name);
    for (int i = 0; i < 64; i++) begin
      if (frame_done === 1'b1) return;
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: frame_done timeout got 0 want 1", name);
  endtask

  // One full frame starting at its first cycle; optional loads at (digit, cycle) positions.
  task automatic do_frame(input vec_t v, input string name,
                          input int a_d, input int a_c, input logic [15:0] a_b, input logic [3:0] a_p,
                          input int b_d, input int b_c, input logic [15:0] b_b, input logic [3:0] b_p);
    push_frame(v);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) check_next($sformatf("%s d%0d", name, d));
        load = 1'b0;
        if (d == a_d && c == a_c) begin load = 1'b1; bcd_in = a_b; dp_in = a_p; end
        if (d == b_d && c == b_c) begin load = 1'b1; bcd_in = b_b; dp_in = b_p; end
        @(negedge clk);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h0305, 4'b0010, 16'hF305, 4'b0010};
    tbl[1] = '{16'h1234, 4'b1111, 16'h1234, 4'b1111};
    tbl[2] = '{16'h0000, 4'b1111, 16'hFFF0, 4'b0001};
    tbl[3] = '{16'h00A0, 4'b0000, 16'hFFA0, 4'b0000};
    tbl[4] = '{16'hF000, 4'b1000, 16'hF000, 4'b1000};
    tbl[5] = '{16'h9001, 4'b0100, 16'h9001, 4'b0100};
    tbl[6] = '{16'h0050, 4'b1010, 16'hFF50, 4'b0010};
    tbl[7] = '{16'h0007, 4'b0000, 16'hFFF7, 4'b0000};
    rst_frame = '{16'h0000, 4'b0000, 16'hFFF0, 4'b0000};

    rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    push_one(4'b0001, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    check_next("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      push_one(4'(1 << ((k / 4) % 4)), ((k / 4) % 4 == 0) ? 4'h0 : 4'hF, 1'b0, 4'h0, 1'b0, k == 16);
      check_next($sformatf("scan c%0d", k));
      @(negedge clk);
    end

    sync_frame("sync0");
    cur = rst_frame;
    for (int v = 0; v < 8; v++) begin
      do_frame(cur, $sformatf("v%0d old", v), 1, 1, tbl[v].bcd, tbl[v].dp, -1, 0, 16'h0, 4'h0);
      cur = tbl[v];
      do_frame(cur, $sformatf("v%0d new", v), -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);
    end

    do_frame(cur, "dbl old", 1, 1, 16'h1234, 4'b1111, 2, 2, 16'h0009, 4'b0000);
    cur = '{16'h0009, 4'b0000, 16'hFFF9, 4'b0000};
    do_frame(cur, "dbl new", -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);
    do_frame(cur, "dbl hold", -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);

    do_frame(cur, "edge old", 1, 1, 16'h0055, 4'b0000, 3, 3, 16'h4321, 4'b0000);
    cur = '{16'h4321, 4'b0000, 16'h4321, 4'b0000};
    do_frame(cur, "edge new", -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);
    do_frame(cur, "edge hold", -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);

    repeat (5) @(negedge clk);
    load = 1'b1; bcd_in = 16'h0808; dp_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_one(4'b0001, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    check_next("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    sync_frame("sync1");
    do_frame(rst_frame, "post reset", -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
